// File: rtl/trg_spi_rx.sv
// trg_spi_rx -- SPI mode-0 slave receiver for trigger commands.
//
// Receives fixed-length frames (MSB first) on an asynchronous SPI link,
// validates the frame length when chip select rises, and presents the decoded
// command on a valid/ready interface toward the trigger-pulse stage.
//
// Ports:
//   clk_50     in   system clock, all logic on its rising edge
//   reset_n    in   synchronous active-low reset
//   spi_clk    in   asynchronous SPI clock (mode 0)
//   spi_cs     in   asynchronous chip select, active-low
//   spi_mosi   in   asynchronous serial data, MSB first
//   cmd_valid  out  a command is held on cmd_op/cmd_mask/cmd_data
//   cmd_ready  in   downstream accepts the command
//   cmd_op     out  opcode, frame bits [15:13]
//   cmd_mask   out  trigger channel mask, frame bits [12:8]
//   cmd_data   out  operand, frame bits [7:0]
//   frame_err  out  one-cycle pulse: frame had the wrong bit count
//   overrun    out  one-cycle pulse: good frame dropped, command still pending
//   frame_cnt  out  count of accepted good frames, wrapping
module trg_spi_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [4:0] cmd_mask,
    output logic [7:0] cmd_data,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] frame_cnt
);

    localparam int         SR_W      = (FRAME_BITS < 16) ? 16 : FRAME_BITS;
    localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);
    // Cycles after reset until the edge-detect pair reflects the real pins.
    localparam logic [7:0] FLUSH_END = 8'(SYNC_STAGES + 2);

    // A pending command (the HOLD condition) is tracked by cmd_valid_q, so the
    // receive FSM itself only needs IDLE and SHIFT.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic clk_e_q, clk_e_d, clk_p_q, clk_p_d;
    logic cs_e_q, cs_e_d, cs_p_q, cs_p_d;
    logic mosi_e_q, mosi_e_d;
    logic [7:0] flush_q, flush_d;
    logic armed_q, armed_d;
    state_t state_q, state_d;
    logic [SR_W-1:0] sreg_q, sreg_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_op_q, cmd_op_d;
    logic [4:0] cmd_mask_q, cmd_mask_d;
    logic [7:0] cmd_data_q, cmd_data_d;
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic clk_rise, cs_rise, cs_fall, enter_shift, frame_done;

    // Synchronizers followed by the edge-detect stage. mosi goes through the
    // same depth as spi_clk so a sampled bit lines up with its clock edge.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        clk_e_d     = clk_sync_q[SYNC_STAGES-1];
        cs_e_d      = cs_sync_q[SYNC_STAGES-1];
        mosi_e_d    = mosi_sync_q[SYNC_STAGES-1];
        clk_p_d     = clk_e_q;
        cs_p_d      = cs_e_q;
    end

    assign clk_rise = clk_e_q & ~clk_p_q;
    assign cs_rise  = cs_e_q & ~cs_p_q;
    assign cs_fall  = ~cs_e_q & cs_p_q;

    // Reset forces the cs synchronizer high; if the pin is actually low when
    // reset releases, that looks like a falling edge. Only arm frame reception
    // once the pipeline has flushed and cs has been seen genuinely high.
    always_comb begin
        flush_d = (flush_q == FLUSH_END) ? flush_q : flush_q + 8'd1;
        armed_d = armed_q | ((flush_q == FLUSH_END) & cs_e_q & cs_p_q);
    end

    assign enter_shift = (state_q == IDLE) && armed_q && cs_fall;
    assign frame_done  = (state_q == SHIFT) && cs_rise;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enter_shift) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register, frame validation and command handshake.
    always_comb begin
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_op_d    = cmd_op_q;
        cmd_mask_d  = cmd_mask_q;
        cmd_data_d  = cmd_data_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        cmd_valid_d = cmd_valid_q & ~cmd_ready;

        if (enter_shift) begin
            sreg_d    = '0;
            bit_cnt_d = '0;
        end else if ((state_q == SHIFT) && !cs_rise && clk_rise) begin
            sreg_d    = {sreg_q[SR_W-2:0], mosi_e_q};
            bit_cnt_d = (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
        end

        if (frame_done) begin
            if (bit_cnt_q == FRAME_LEN) begin
                // Free slot, or the pending command leaves on this same edge.
                if (!cmd_valid_q || cmd_ready) begin
                    cmd_op_d    = sreg_q[15:13];
                    cmd_mask_d  = sreg_q[12:8];
                    cmd_data_d  = sreg_q[7:0];
                    cmd_valid_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            clk_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            clk_e_q     <= 1'b0;
            clk_p_q     <= 1'b0;
            cs_e_q      <= 1'b1;
            cs_p_q      <= 1'b1;
            mosi_e_q    <= 1'b0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_mask_q  <= '0;
            cmd_data_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            clk_e_q     <= clk_e_d;
            clk_p_q     <= clk_p_d;
            cs_e_q      <= cs_e_d;
            cs_p_q      <= cs_p_d;
            mosi_e_q    <= mosi_e_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_mask_q  <= cmd_mask_d;
            cmd_data_q  <= cmd_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_mask  = cmd_mask_q;
    assign cmd_data  = cmd_data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule
